// File: rtl/csi_addr_pack.sv
// csi_addr_pack
//   Buffers CsI address events and streams one packed coordinate word per
//   channel. Sparse events emit only hit channels; dense events emit all NCH
//   channels in the legacy order. An empty sparse event still emits one
//   marker word so that the event boundary stays visible downstream.
//
// Optional feature: `CSI_ADDR_PACK_DROP_EN
//   When defined, in_ready stays high and events that arrive while the FIFO
//   is full are discarded and counted in drop_cnt, which saturates.
//   When undefined, back-pressure is lossless and drop_cnt is held at 0.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  event handshake; in_ready = FIFO not full
//   addr               NCH 16-bit slots: x = slot[CW-1:0], y = slot[8+CW-1:8]
//   hit, flag, sparse  per-channel hit mask, global flag, mode (per event)
//   out_valid/out_ready word handshake
//   out_word           {rsvd=0, last, flag, hit, y, x}
//   out_chan           channel index of out_word
//   ev_count           completed events (wraps)
//   drop_cnt           dropped events (saturates; 0 without the macro)
//   dbg_state          current FSM state (0 = IDLE, 1 = EMIT)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready, and while valid is high and
// ready low the payload holds stable.

module csi_addr_pack #(
    parameter int NCH      = 16,
    parameter int CW       = 6,
    parameter int EV_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NCH*16-1:0]       addr,
    input  logic [NCH-1:0]          hit,
    input  logic                    flag,
    input  logic                    sparse,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*CW+3:0]         out_word,
    output logic [$clog2(NCH)-1:0]  out_chan,
    output logic [15:0]             ev_count,
    output logic [15:0]             drop_cnt,
    output logic                    dbg_state
);

    localparam int CHW = $clog2(NCH);
    localparam int AW  = $clog2(EV_DEPTH);
    localparam int EW  = NCH*16 + NCH + 2;
    localparam int WW  = 2*CW + 4;

    typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

    // Lowest set bit of a mask; 0 for an empty mask.
    function automatic logic [CHW-1:0] lowest(input logic [NCH-1:0] m);
        logic [CHW-1:0] r;
        r = '0;
        for (int i = NCH-1; i >= 0; i--) begin
            if (m[i]) r = CHW'(i);
        end
        return r;
    endfunction

    // At most one bit left: the selected channel is the final one.
    function automatic logic is_last(input logic [NCH-1:0] m);
        return (m & (m - NCH'(1))) == '0;
    endfunction

    // ---------------- event FIFO ----------------
    logic [EW-1:0]  mem_q [EV_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    cnt_q;
    logic           full, empty, push, pop;
    logic [EW-1:0]  head;

    assign full  = (cnt_q == (AW+1)'(EV_DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // ---------------- working registers ----------------
    state_t           state_q, state_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [NCH*16-1:0] addr_q, addr_d;
    logic [NCH-1:0]   hit_q, hit_d;
    logic             flag_q, flag_d;
    logic [15:0]      ev_count_q, ev_count_d;
    logic             out_valid_q;
    logic [WW-1:0]    out_word_q, out_word_d;
    logic [CHW-1:0]   out_chan_q, out_chan_d;

    logic             xfer, cur_last;
    logic [CHW-1:0]   cur_chan, nxt_chan;
    logic [15:0]      nxt_slot;

    assign xfer     = (state_q == S_EMIT) && out_ready;
    assign cur_chan = lowest(mask_q);
    assign cur_last = is_last(mask_q);
    // Pop when idle, or when the final word of an event transfers so the
    // next event starts without a bubble.
    assign pop      = !empty && ((state_q == S_IDLE) || (xfer && cur_last));

`ifdef CSI_ADDR_PACK_DROP_EN
    logic        drop;
    logic [15:0] drop_cnt_q;
    assign in_ready = !rst;
    // A pop on the same edge frees a slot, so that push is still accepted.
    assign push     = in_valid && (!full || pop);
    assign drop     = in_valid && full && !pop;
    always_ff @(posedge clk) begin
        if (rst)                            drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
    assign drop_cnt = drop_cnt_q;
`else
    assign in_ready = !rst && !full;
    assign push     = in_valid && !full;
    assign drop_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {sparse, flag, hit, addr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        hit_d      = hit_q;
        flag_d     = flag_q;
        ev_count_d = ev_count_q;
        if (xfer) begin
            mask_d = mask_q & ~(NCH'(1) << cur_chan);
            if (cur_last) begin
                ev_count_d = ev_count_q + 16'd1;
                state_d    = S_IDLE;
            end
        end
        if (pop) begin
            addr_d  = head[NCH*16-1:0];
            hit_d   = head[NCH*16 +: NCH];
            flag_d  = head[EW-2];
            mask_d  = head[EW-1] ? head[NCH*16 +: NCH] : '1;
            state_d = S_EMIT;
        end
    end

    // Output word is computed from the next working state so that it is
    // registered and ready on the same edge the selection advances.
    always_comb begin
        nxt_chan   = lowest(mask_d);
        nxt_slot   = addr_d[int'(nxt_chan)*16 +: 16];
        out_word_d = '0;
        out_chan_d = '0;
        if (state_d == S_EMIT) begin
            if (mask_d == '0) begin
                // empty sparse event marker
                out_word_d = {1'b0, 1'b1, flag_d, 1'b0, {(2*CW){1'b0}}};
            end else begin
                out_word_d = {1'b0, is_last(mask_d), flag_d, hit_d[nxt_chan],
                              nxt_slot[8 +: CW], nxt_slot[0 +: CW]};
                out_chan_d = nxt_chan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            addr_q      <= '0;
            hit_q       <= '0;
            flag_q      <= 1'b0;
            ev_count_q  <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            hit_q       <= hit_d;
            flag_q      <= flag_d;
            ev_count_q  <= ev_count_d;
            out_valid_q <= (state_d == S_EMIT);
            out_word_q  <= out_word_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_chan  = out_chan_q;
    assign ev_count  = ev_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_csi_addr_pack.sv
module tb_csi_addr_pack;

  localparam int NCH = 16;
  localparam int CW  = 6;
  localparam int WW  = 2*CW + 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NCH*16-1:0] addr;
  logic [NCH-1:0]    hit;
  logic              flag;
  logic              sparse;
  logic              out_valid;
  logic              out_ready;
  logic [WW-1:0]     out_word;
  logic [3:0]        out_chan;
  logic [15:0]       ev_count;
  logic [15:0]       drop_cnt;
  logic              dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  csi_addr_pack #(.NCH(NCH), .CW(CW), .EV_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .hit(hit), .flag(flag), .sparse(sparse),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_chan(out_chan), .ev_count(ev_count), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] mk_word(input logic last, input logic f, input logic h,
                                          input int y, input int x);
    logic [5:0] yy, xx;
    yy = 6'(y);
    xx = 6'(x);
    return {1'b0, last, f, h, yy, xx};
  endfunction

  // slot i = {i+32, i}: x = i, y = i+32
  function automatic logic [NCH*16-1:0] pat1();
    logic [NCH*16-1:0] a;
    for (int i = 0; i < NCH; i++) a[16*i +: 16] = {8'(i+32), 8'(i)};
    return a;
  endfunction

  // slot i = {0x40|(i+1), 0x80|(2i)}: upper bits beyond CW must be ignored,
  // so x = 2i, y = i+1
  function automatic logic [NCH*16-1:0] pat2();
    logic [NCH*16-1:0] a;
    for (int i = 0; i < NCH; i++) a[16*i +: 16] = {8'(8'h40 | (i+1)), 8'(8'h80 | (2*i))};
    return a;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic push_ev(input logic [NCH*16-1:0] a, input logic [NCH-1:0] h,
                         input logic f, input logic s);
    int n;
    addr = a; hit = h; flag = f; sparse = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input int ch, input logic [15:0] w);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_chan"},  32'(out_chan),  32'(ch));
    check({tag, "_word"},  32'(out_word),  32'(w));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r, stalled;
    logic [15:0] held_word;
    logic [3:0]  held_chan;
    logic [15:0] hp;
    int          ch, cyc;

    rst = 1'b1; in_valid = 1'b0; addr = '0; hit = '0; flag = 1'b0; sparse = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_word",  32'(out_word),  0);
    check("rst_out_chan",  32'(out_chan),  0);
    check("rst_ev_count",  32'(ev_count),  0);
    check("rst_drop_cnt",  32'(drop_cnt),  0);
    check("rst_in_ready",  32'(in_ready),  0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);
    check("post_rst_state",    32'(dbg_state), 0);

    // dense event, first-word latency, then 16 consecutive words
    push_ev(pat1(), 16'h0005, 1'b1, 1'b0);
    check("dense_lat_idle", 32'(out_valid), 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      expect_word("dense", i, mk_word(i == 15, 1'b1, (i == 0) || (i == 2), i+32, i));
      @(negedge clk);
    end
    check("dense_done_valid", 32'(out_valid), 0);
    check("dense_ev_count",   32'(ev_count),  1);

    // sparse 0x8101: channels 0, 8, 15 on consecutive cycles
    push_ev(pat2(), 16'h8101, 1'b0, 1'b1);
    @(negedge clk);
    expect_word("sp_a", 0,  mk_word(1'b0, 1'b0, 1'b1, 1,  0));
    @(negedge clk);
    expect_word("sp_b", 8,  mk_word(1'b0, 1'b0, 1'b1, 9,  16));
    @(negedge clk);
    expect_word("sp_c", 15, mk_word(1'b1, 1'b0, 1'b1, 16, 30));
    @(negedge clk);
    check("sp_done_valid", 32'(out_valid), 0);
    check("sp_ev_count",   32'(ev_count),  2);

    // empty sparse event: single marker word (flag bit masked out)
    push_ev(pat2(), 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    check("empty_valid", 32'(out_valid), 1);
    check("empty_chan",  32'(out_chan),  0);
    check("empty_word",  32'(out_word & 16'hDFFF), 32'h4000);
    @(negedge clk);
    check("empty_done_valid", 32'(out_valid), 0);
    check("empty_state",      32'(dbg_state), 0);
    check("empty_ev_count",   32'(ev_count),  3);

    // back-pressure: the first event moves into the working registers, so
    // five accepts leave the 4-deep FIFO full
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) push_ev(pat2(), 16'((1 << j) | (1 << (j+8))), 1'(j), 1'b1);
`ifdef CSI_ADDR_PACK_DROP_EN
    check("bp_in_ready_tied", 32'(in_ready), 1);
    addr = pat1(); hit = 16'hFFFF; flag = 1'b0; sparse = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_drop_cnt", 32'(drop_cnt), 1);
`else
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_drop_cnt", 32'(drop_cnt), 0);
`endif
    expect_word("bp_hold", 0, mk_word(1'b0, 1'b0, 1'b1, 1, 0));
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ch = (k / 2) + 8 * (k % 2);
      expect_word("bp", ch, mk_word(1'(k % 2), 1'((k / 2) % 2), 1'b1, ch+1, 2*ch));
      @(negedge clk);
    end
    check("bp_done_valid", 32'(out_valid), 0);
    check("bp_ev_count",   32'(ev_count),  8);

    // stall stability with random out_ready, scoreboard of {chan, word}
    hp = 16'hA50F;
    for (int i = 0; i < 16; i++)
      exp_q.push_back({16'(i), mk_word(i == 15, 1'b0, hp[i], i+32, i)});
    out_ready = 1'b0;
    push_ev(pat1(), hp, 1'b0, 1'b0);
    stalled = 1'b0; held_word = '0; held_chan = '0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      if (stalled) begin
        check("stall_word", 32'(out_word), 32'(held_word));
        check("stall_chan", 32'(out_chan), 32'(held_chan));
      end
      if (out_valid) check("stall_seq", {16'(out_chan), out_word}, exp_q[0]);
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      if (out_valid && r) void'(exp_q.pop_front());
      stalled   = out_valid && !r;
      held_word = out_word;
      held_chan = out_chan;
      @(negedge clk);
      cyc++;
    end
    check("stall_drained",  32'(exp_q.size()), 0);
    check("stall_done",     32'(out_valid),    0);
    check("stall_ev_count", 32'(ev_count),     9);
    out_ready = 1'b1;

    // reset mid-event after 3 dense words
    push_ev(pat1(), 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("mid_chan_before", 32'(out_chan), 3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid",    32'(out_valid), 0);
    check("mid_rst_ev_count", 32'(ev_count),  0);
    check("mid_rst_word",     32'(out_word),  0);
    check("mid_rst_in_ready", 32'(in_ready),  0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_in_ready", 32'(in_ready),  1);
    check("mid_post_valid",    32'(out_valid), 0);
    push_ev(pat1(), 16'h0002, 1'b1, 1'b0);
    @(negedge clk);
    expect_word("mid_new", 0, mk_word(1'b0, 1'b1, 1'b0, 32, 0));
    repeat (16) @(negedge clk);
    check("mid_new_done",     32'(out_valid), 0);
    check("mid_new_ev_count", 32'(ev_count),  1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog: a hang still reaches a FAIL line
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
